// File: rtl/pwm_duty_controller_if.sv
// Control/status bundle between the duty sequencer and its requester/comparator.
// The master drives enable and duty requests; the slave returns ack, sawtooth, duty and status.
interface pwm_duty_controller_if #(
    parameter int WIDTH = 10
);
    logic             enable;
    logic             duty_req;
    logic [WIDTH-1:0] duty_in;
    logic             duty_ack;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] duty;
    logic             period_start;
    logic             busy;

    modport master (
        output enable, duty_req, duty_in,
        input  duty_ack, count, duty, period_start, busy
    );

    modport slave (
        input  enable, duty_req, duty_in,
        output duty_ack, count, duty, period_start, busy
    );
endinterface

// File: rtl/pwm_duty_controller.sv
// PWM sequencer: free-running sawtooth plus a duty value that only changes at period wraps.
// Define PWM_SOFTSTART_EN to ramp duty by STEP per period; otherwise duty jumps to target.
module pwm_duty_controller #(
    parameter int WIDTH    = 10,
    parameter int STEP     = 8,
    parameter int PRESCALE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    pwm_duty_controller_if.slave bus
);
    localparam int               PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {IDLE, RAMP, HOLD} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic             duty_ack_q, duty_ack_d;
    logic             period_start_q, period_start_d;
    logic             busy;
    logic             tick;
    logic             wrap;
    logic [WIDTH-1:0] ramp_duty;

    assign tick = (state_q != IDLE) && (presc_q == PRE_LAST);
    assign wrap = tick && (count_q == CNT_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            presc_q        <= '0;
            count_q        <= '0;
            duty_q         <= '0;
            target_q       <= '0;
            duty_ack_q     <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            presc_q        <= presc_d;
            count_q        <= count_d;
            duty_q         <= duty_d;
            target_q       <= target_d;
            duty_ack_q     <= duty_ack_d;
            period_start_q <= period_start_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!bus.enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = (target_q != '0) ? RAMP : HOLD;
                RAMP:    if (duty_q == target_q) state_d = HOLD;
                HOLD:    if (target_q != duty_q) state_d = RAMP;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state_q == RAMP);
    end

`ifdef PWM_SOFTSTART_EN
    localparam logic [WIDTH:0] STEP_W = (WIDTH + 1)'(STEP);
    logic [WIDTH:0] duty_ext;
    logic [WIDTH:0] tgt_ext;
    logic [WIDTH:0] up_ext;

    // Widened compares keep both saturating directions free of wrap/underflow.
    always_comb begin
        duty_ext  = {1'b0, duty_q};
        tgt_ext   = {1'b0, target_q};
        up_ext    = duty_ext + STEP_W;
        ramp_duty = target_q;
        if (tgt_ext > duty_ext) begin
            ramp_duty = (up_ext > tgt_ext) ? target_q : up_ext[WIDTH-1:0];
        end else if (duty_ext >= tgt_ext + STEP_W) begin
            ramp_duty = duty_q - STEP_W[WIDTH-1:0];
        end
    end
`else
    always_comb begin
        ramp_duty = target_q;
    end
`endif

    // Target updates every cycle, but the wrap edge reads target_q, so a same-cycle
    // request only takes effect at the following boundary.
    always_comb begin
        presc_d        = presc_q;
        count_d        = count_q;
        duty_d         = duty_q;
        period_start_d = 1'b0;
        target_d       = bus.duty_req ? bus.duty_in : target_q;
        duty_ack_d     = bus.duty_req;
        if (state_q == IDLE || !bus.enable) begin
            presc_d = '0;
            count_d = '0;
            duty_d  = '0;
        end else begin
            presc_d = (presc_q == PRE_LAST) ? '0 : presc_q + 1'b1;
            if (tick) count_d = count_q + 1'b1;
            if (wrap) begin
                period_start_d = 1'b1;
                if (state_q == RAMP) duty_d = ramp_duty;
            end
        end
    end

    assign bus.duty_ack     = duty_ack_q;
    assign bus.count        = count_q;
    assign bus.duty         = duty_q;
    assign bus.period_start = period_start_q;
    assign bus.busy         = busy;
endmodule

// File: tb/tb_pwm_duty_controller.sv
// Scenario bench for pwm_duty_controller: expected duty values per boundary are queued
// when a target is requested and popped at each period_start.
module tb_pwm_duty_controller;
    localparam int WIDTH    = 10;
    localparam int STEP     = 8;
    localparam int PRESCALE = 1;
    localparam int PER      = 1 << WIDTH;
`ifdef PWM_SOFTSTART_EN
    localparam int NEWT = 124;
`else
    localparam int NEWT = 900;
`endif

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;
    int   tgt;
    int   model_duty;
    int   exp_q[$];

    pwm_duty_controller_if #(.WIDTH(WIDTH)) ifc ();

    pwm_duty_controller #(.WIDTH(WIDTH), .STEP(STEP), .PRESCALE(PRESCALE)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int next_duty(input int d, input int t);
`ifdef PWM_SOFTSTART_EN
        if (t > d) return (d + STEP > t) ? t : d + STEP;
        return (d - STEP < t) ? t : d - STEP;
`else
        return t;
`endif
    endfunction

    task automatic wait_ps(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < PER * PRESCALE + 16; i++) begin
            @(negedge clk);
            if (ifc.period_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_period_start: no period_start within %0d cycles", PER * PRESCALE + 16);
        end
    endtask

    task automatic wait_count(input int c, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < PER * PRESCALE + 16; i++) begin
            @(negedge clk);
            if (ifc.count == c) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_count: count never reached %0d", c);
        end
    endtask

    task automatic do_req(input int v);
        @(negedge clk);
        ifc.duty_req = 1'b1;
        ifc.duty_in  = v[WIDTH-1:0];
        @(negedge clk);
        ifc.duty_req = 1'b0;
        n_cmp++;
        if (ifc.duty_ack !== 1'b1) begin
            n_bad++; $display("FAIL req_ack(%0d): duty_ack=%b expected 1", v, ifc.duty_ack);
        end
        @(negedge clk);
        n_cmp++;
        if (ifc.duty_ack !== 1'b0) begin
            n_bad++; $display("FAIL req_ack_drop(%0d): duty_ack=%b expected 0", v, ifc.duty_ack);
        end
        tgt = v;
        $display("req target=%0d accepted at count=%0d", v, ifc.count);
    endtask

    task automatic build_sb();
        int d;
        exp_q.delete();
        d = model_duty;
        while (d != tgt) begin
            d = next_duty(d, tgt);
            exp_q.push_back(d);
        end
    endtask

    task automatic consume(input int max_n);
        int  n;
        int  e;
        bit  ok;
        n = 0;
        while (exp_q.size() > 0 && n < max_n) begin
            wait_ps(ok);
            if (!ok) return;
            e = exp_q.pop_front();
            n_cmp++;
            if (ifc.duty !== e[WIDTH-1:0]) begin
                n_bad++; $display("FAIL boundary_duty: duty=%0d expected %0d", ifc.duty, e);
            end
            n_cmp++;
            if (ifc.count !== '0) begin
                n_bad++; $display("FAIL boundary_count: count=%0d expected 0", ifc.count);
            end
            n_cmp++;
            if (ifc.busy !== 1'b1) begin
                n_bad++; $display("FAIL boundary_busy: busy=%b expected 1", ifc.busy);
            end
            $display("boundary duty=%0d expected=%0d busy=%b", ifc.duty, e, ifc.busy);
            model_duty = e;
            if (exp_q.size() == 0) begin
                @(negedge clk);
                n_cmp++;
                if (ifc.busy !== 1'b0) begin
                    n_bad++; $display("FAIL busy_drop: busy=%b expected 0", ifc.busy);
                end
            end
            n++;
        end
    endtask

    task automatic test_reset_state();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (ifc.count !== '0 || ifc.duty !== '0 || ifc.busy !== 1'b0 ||
            ifc.duty_ack !== 1'b0 || ifc.period_start !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: count=%0d duty=%0d busy=%b ack=%b ps=%b expected all 0",
                     ifc.count, ifc.duty, ifc.busy, ifc.duty_ack, ifc.period_start);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (ifc.count !== '0) begin
            n_bad++; $display("FAIL idle_count: count=%0d expected 0", ifc.count);
        end
        $display("reset state checked");
    endtask

    task automatic test_zero_target();
        int cnt;
        int prev;
        bit ok;
        for (int p = 0; p < 2; p++) begin
            if (p == 0) ifc.enable = 1'b1;
            cnt = 0; prev = -1; ok = 1'b0;
            for (int i = 0; i < PER * PRESCALE + 16; i++) begin
                @(negedge clk);
                cnt++;
                if (ifc.period_start === 1'b1) begin ok = 1'b1; break; end
                prev = int'(ifc.count);
            end
            n_cmp++;
            if (!ok || cnt != PER * PRESCALE + (p == 0 ? 1 : 0)) begin
                n_bad++; $display("FAIL period_len[%0d]: cycles=%0d expected %0d", p, cnt,
                                  PER * PRESCALE + (p == 0 ? 1 : 0));
            end
            n_cmp++;
            if (prev != PER - 1) begin
                n_bad++; $display("FAIL pre_wrap_count: count=%0d expected %0d", prev, PER - 1);
            end
            n_cmp++;
            if (ifc.count !== '0 || ifc.duty !== '0 || ifc.busy !== 1'b0) begin
                n_bad++; $display("FAIL zero_target: count=%0d duty=%0d busy=%b expected 0/0/0",
                                  ifc.count, ifc.duty, ifc.busy);
            end
            $display("period %0d length=%0d duty=%0d", p, cnt, ifc.duty);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        ifc.duty_req = 1'b1;
        ifc.duty_in  = 10'd500;
        @(negedge clk);
        ifc.duty_in  = 10'd100;
        n_cmp++;
        if (ifc.duty_ack !== 1'b1) begin
            n_bad++; $display("FAIL b2b_ack0: duty_ack=%b expected 1", ifc.duty_ack);
        end
        @(negedge clk);
        ifc.duty_req = 1'b0;
        n_cmp++;
        if (ifc.duty_ack !== 1'b1) begin
            n_bad++; $display("FAIL b2b_ack1: duty_ack=%b expected 1", ifc.duty_ack);
        end
        @(negedge clk);
        n_cmp++;
        if (ifc.duty_ack !== 1'b0 || ifc.duty !== '0) begin
            n_bad++; $display("FAIL b2b_after: ack=%b duty=%0d expected 0/0", ifc.duty_ack, ifc.duty);
        end
        tgt = 100;
        $display("back-to-back requests 500,100 issued");
    endtask

    task automatic test_softstart();
        build_sb();
        consume(1000);
    endtask

    task automatic test_request_mid_period();
        bit ok;
        wait_count(300, ok);
        do_req(NEWT);
        n_cmp++;
        if (ifc.duty !== model_duty[WIDTH-1:0]) begin
            n_bad++; $display("FAIL mid_period_hold: duty=%0d expected %0d", ifc.duty, model_duty);
        end
        wait_count(1000, ok);
        n_cmp++;
        if (ifc.duty !== model_duty[WIDTH-1:0]) begin
            n_bad++; $display("FAIL pre_wrap_hold: duty=%0d expected %0d", ifc.duty, model_duty);
        end
        build_sb();
        consume(1000);
    endtask

    task automatic test_midramp();
        ifc.enable = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (ifc.duty !== '0 || ifc.count !== '0 || ifc.busy !== 1'b0) begin
            n_bad++; $display("FAIL disable: duty=%0d count=%0d busy=%b expected 0/0/0",
                              ifc.duty, ifc.count, ifc.busy);
        end
        model_duty = 0;
        do_req(100);
        ifc.enable = 1'b1;
        build_sb();
        consume(6);
        do_req(20);
        build_sb();
        consume(1000);
    endtask

    task automatic test_enable_drop();
        do_req(200);
        build_sb();
        consume(1000);
        @(negedge clk);
        ifc.enable = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (ifc.duty !== '0 || ifc.count !== '0 || ifc.busy !== 1'b0 || ifc.period_start !== 1'b0) begin
            n_bad++; $display("FAIL enable_drop: duty=%0d count=%0d busy=%b ps=%b expected 0",
                              ifc.duty, ifc.count, ifc.busy, ifc.period_start);
        end
        repeat (5) @(negedge clk);
        n_cmp++;
        if (ifc.count !== '0) begin
            n_bad++; $display("FAIL idle_hold: count=%0d expected 0", ifc.count);
        end
        model_duty = 0;
        ifc.enable = 1'b1;
        build_sb();
        consume(8);
    endtask

    task automatic test_reset_midrun();
        bit ok;
        wait_count(500, ok);
        n_cmp++;
        if (ifc.duty !== model_duty[WIDTH-1:0]) begin
            n_bad++; $display("FAIL pre_reset_duty: duty=%0d expected %0d", ifc.duty, model_duty);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (ifc.count !== '0 || ifc.duty !== '0 || ifc.busy !== 1'b0 ||
            ifc.duty_ack !== 1'b0 || ifc.period_start !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: count=%0d duty=%0d busy=%b ack=%b ps=%b expected all 0",
                     ifc.count, ifc.duty, ifc.busy, ifc.duty_ack, ifc.period_start);
        end
        ifc.enable = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (ifc.count !== '0 || ifc.duty !== '0) begin
            n_bad++; $display("FAIL post_reset_idle: count=%0d duty=%0d expected 0/0",
                              ifc.count, ifc.duty);
        end
        $display("reset mid-run checked");
    endtask

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        tgt          = 0;
        model_duty   = 0;
        reset        = 1'b1;
        ifc.enable   = 1'b0;
        ifc.duty_req = 1'b0;
        ifc.duty_in  = '0;
        test_reset_state();
        test_zero_target();
        test_back_to_back();
        test_softstart();
        test_request_mid_period();
        test_midramp();
        test_enable_drop();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pwm_duty_controller.md
# pwm_duty_controller

Sequencer for the 10-bit PWM comparator stage: generates the free-running sawtooth count fed to the comparator's reference input and the duty value fed to its threshold input. Accepts new duty targets from the control logic through a req/ack handshake and applies them only at period boundaries, ramping toward the target in fixed steps for soft start. Sits between the user/control FSM and the comparator that drives the PWM pin.

## Interface
- WIDTH, 10, width of count, duty and target
- STEP, 8, duty increment/decrement per period while ramping (1..2^WIDTH-1)
- PRESCALE, 1, clk cycles per count tick (>=1)
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- enable  in  1  level; 1 = PWM running, 0 = idle
- duty_req  in  1  request to load duty_in as new target
- duty_in  in  WIDTH  requested target duty
- duty_ack  out  1  one-cycle pulse: request accepted
- count  out  WIDTH  sawtooth to comparator reference input
- duty  out  WIDTH  current applied duty to comparator threshold input
- period_start  out  1  one-cycle pulse when count wraps to 0
- busy  out  1  high while ramping (duty != target)

## Operation
- Reset values: count=0, duty=0, target=0, prescaler=0, duty_ack=0, period_start=0, busy=0, state=IDLE.
- Downstream comparator output is high while count <= duty.
- Prescaler: tick asserted every PRESCALE clk cycles while not IDLE; PRESCALE=1 means tick every cycle.
- Count: +1 per tick, wraps 2^WIDTH-1 -> 0; a wrap is a period boundary.
- Handshake: duty_req sampled every cycle in every state; when high, target <= duty_in and duty_ack high the following cycle for one cycle. Requester drops duty_req after ack; req held high is re-accepted every cycle (last value wins). Target written at any point in a period; duty unaffected until boundary.
- States:
  - IDLE: count, prescaler held at 0; duty forced 0; busy=0. enable=1 -> RAMP if target!=0, else HOLD (next cycle).
  - RAMP: busy=1. At each boundary duty steps toward target (see Configuration). Goes to HOLD in the cycle after the update that makes duty==target.
  - HOLD: busy=0. Target change to a value != duty -> RAMP next cycle.
  - Any state with enable=0 -> IDLE next cycle; duty cleared to 0, target retained.
- Arithmetic: step computed in WIDTH+1 bits; up-step saturates at target (min(duty+STEP, target)), down-step saturates at target (max(duty-STEP, target)); never wraps, never underflows.
- Boundary where target changes in the same cycle as the wrap: update uses the old target; new target used from next boundary.

## Timing
- count and duty registered; both change on the same clk edge at a boundary, so the comparator never sees a mixed old/new pair.
- period_start high in the cycle count reads 0 after a wrap (not on IDLE exit).
- Period = PRESCALE * 2^WIDTH clk cycles; first boundary after enable occurs 2^WIDTH ticks after leaving IDLE.
- duty_ack latency: 1 cycle after duty_req sampled high.
- Reset asserted mid-period: all outputs return to reset values immediately, asynchronously; operation resumes from IDLE on first edge after release.

## Configuration
- PWM_SOFTSTART_EN defined: duty ramps by STEP per boundary as above; busy meaningful.
- PWM_SOFTSTART_EN undefined: at first boundary after target change, duty <= target directly; RAMP lasts at most one period; STEP ignored.

## Test plan
- Reset mid-run (count=500, duty=64) -> count=0, duty=0, busy=0, duty_ack=0 immediately, state IDLE.
- PRESCALE=1, enable=1, target=0 -> period_start every 1024 cycles, count wraps 1023->0, duty stays 0, busy=0.
- Soft start on, target=100, STEP=8 -> duty 8,16,...,96 over 12 boundaries, 100 at 13th, busy drops next cycle.
- Mid-ramp (duty=48) request duty_in=20 -> duty_ack one cycle later; next boundaries give 40, 32, 24, 20, then HOLD.
- Soft start off, HOLD at 100, request 900 at count=300 -> duty stays 100 until wrap, then 900 at boundary.
- enable dropped at duty=200 -> next cycle IDLE, duty=0, count=0; re-enable -> ramps from 0 toward retained target 200.
